// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port (fetch/data) single-outstanding memory arbiter; optional fetch starvation guard via ARB_STARVE_GUARD_EN
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int WAIT_CYC   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_valid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_if_o
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic owner_dm;
  logic done, free, grant, pick_dm;
  assign done = (state == WAIT) && (cnt == 4'd0);
  assign free = (state == IDLE) || done;
  assign grant = free && (if_req_i || dm_req_i);
  assign stall_if_o = if_req_i && !if_gnt_o;
`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve;
  assign pick_dm = dm_req_i && !(if_req_i && starve == 4'(STARVE_MAX));
  // count consecutive data grants that bypass a waiting fetch
  always_ff @(posedge clk)
    if (rst || !if_req_i || (grant && !pick_dm)) starve <= '0;
    else if (grant) starve <= starve + 4'd1;
`else
  assign pick_dm = dm_req_i;
`endif
  // next state: the final wait cycle behaves like idle so a new grant lands with the valid pulse
  always_comb begin
    state_n = state;
    if (free) state_n = grant ? WAIT : IDLE;
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // grant strobes, memory command, latency counter and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      owner_dm    <= 1'b0;
      if_gnt_o    <= 1'b0;
      dm_gnt_o    <= 1'b0;
      if_valid_o  <= 1'b0;
      dm_valid_o  <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      if_gnt_o   <= 1'b0;
      dm_gnt_o   <= 1'b0;
      mem_en_o   <= 1'b0;
      if_valid_o <= done && !owner_dm;
      dm_valid_o <= done && owner_dm;
      if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (done && owner_dm) dm_rdata_o <= mem_we_o ? '0 : mem_rdata_i;
      if (done && !owner_dm) if_rdata_o <= mem_rdata_i;
      if (grant) begin
        owner_dm    <= pick_dm;
        dm_gnt_o    <= pick_dm;
        if_gnt_o    <= !pick_dm;
        mem_en_o    <= 1'b1;
        mem_we_o    <= pick_dm && dm_we_i;
        mem_addr_o  <= pick_dm ? dm_addr_i : if_addr_i;
        mem_wdata_o <= pick_dm ? dm_wdata_i : '0;
        cnt         <= 4'(WAIT_CYC);
      end
    end
  end
endmodule
